// File: rtl/mistral_mac_pipe.sv
// Pipelined multiply-accumulate: input register, optional product register and an
// accumulate/output stage. A single global stall freezes every stage at once.
module mistral_mac_pipe #(
   parameter int A_WIDTH     = 18,
   parameter int B_WIDTH     = 18,
   parameter int A_SIGNED    = 1,
   parameter int B_SIGNED    = 1,
   parameter int ACC_WIDTH   = 64,
   parameter int PRODUCT_REG = 1
) (
   input  logic                 CLK,
   input  logic                 SRST_N,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [A_WIDTH-1:0]   A,
   input  logic [B_WIDTH-1:0]   B,
   input  logic                 LOAD,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [ACC_WIDTH-1:0] Y,
   output logic                 OVF
);
   localparam int PW     = A_WIDTH + B_WIDTH;
   localparam int STAGES = (PRODUCT_REG != 0) ? 2 : 1;
   localparam bit SMODE  = (A_SIGNED != 0) || (B_SIGNED != 0);

   if (A_WIDTH < 1 || A_WIDTH > 27) begin : g_chk_a
      $error("mistral_mac_pipe: A_WIDTH out of range 1..27");
   end
   if (B_WIDTH < 1 || B_WIDTH > 27) begin : g_chk_b
      $error("mistral_mac_pipe: B_WIDTH out of range 1..27");
   end
   if (ACC_WIDTH < PW || ACC_WIDTH > 64) begin : g_chk_acc
      $error("mistral_mac_pipe: ACC_WIDTH out of range A_WIDTH+B_WIDTH..64");
   end
   if (PRODUCT_REG != 0 && PRODUCT_REG != 1) begin : g_chk_preg
      $error("mistral_mac_pipe: PRODUCT_REG must be 0 or 1");
   end

   logic                 stall;
   logic [STAGES:0]      vld_pipe_q, vld_pipe_d;
   logic [A_WIDTH-1:0]   a0_q, a0_d;
   logic [B_WIDTH-1:0]   b0_q, b0_d;
   logic                 load0_q, load0_d;
   logic [PW-1:0]        a_w, b_w, prod, s2_p;
   logic                 s2_load, s2_vld;
   logic [ACC_WIDTH-1:0] p_ext, acc_q, acc_d;
   logic [ACC_WIDTH:0]   sum;
   logic                 ovf_now, ovf_q, ovf_d;

   assign stall     = vld_pipe_q[STAGES] & ~OUT_READY;
   assign IN_READY  = ~stall;
   assign OUT_VALID = vld_pipe_q[STAGES];
   assign Y         = acc_q;
   assign OVF       = ovf_q;
   assign s2_vld    = vld_pipe_q[STAGES-1];

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      a0_d       = a0_q;
      b0_d       = b0_q;
      load0_d    = load0_q;
      if (!stall) begin
         vld_pipe_d = {vld_pipe_q[STAGES-1:0], IN_VALID};
         if (IN_VALID) begin
            a0_d    = A;
            b0_d    = B;
            load0_d = LOAD;
         end
      end
   end

   // Extending both operands to the full product width makes the low PW bits of
   // a plain multiply equal the exact signed/unsigned/mixed product.
   assign a_w  = {{B_WIDTH{(A_SIGNED != 0) & a0_q[A_WIDTH-1]}}, a0_q};
   assign b_w  = {{A_WIDTH{(B_SIGNED != 0) & b0_q[B_WIDTH-1]}}, b0_q};
   assign prod = a_w * b_w;

   if (PRODUCT_REG != 0) begin : g_preg
      logic [PW-1:0] p1_q, p1_d;
      logic          load1_q, load1_d;

      always_comb begin
         p1_d    = p1_q;
         load1_d = load1_q;
         if (!stall && vld_pipe_q[0]) begin
            p1_d    = prod;
            load1_d = load0_q;
         end
      end

      always_ff @(posedge CLK) begin
         if (!SRST_N) begin
            p1_q    <= '0;
            load1_q <= 1'b0;
         end else begin
            p1_q    <= p1_d;
            load1_q <= load1_d;
         end
      end

      assign s2_p    = p1_q;
      assign s2_load = load1_q;
   end else begin : g_nopreg
      assign s2_p    = prod;
      assign s2_load = load0_q;
   end

   always_comb begin
      p_ext         = {ACC_WIDTH{SMODE & s2_p[PW-1]}};
      p_ext[PW-1:0] = s2_p;
   end

   assign sum     = {1'b0, acc_q} + {1'b0, p_ext};
   assign ovf_now = SMODE ? ((acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                             (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                          : sum[ACC_WIDTH];

   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (!stall && s2_vld) begin
         if (s2_load) begin
            acc_d = p_ext;
            ovf_d = 1'b0;
         end else begin
            acc_d = sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | ovf_now;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!SRST_N) begin
         vld_pipe_q <= '0;
         a0_q       <= '0;
         b0_q       <= '0;
         load0_q    <= 1'b0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         a0_q       <= a0_d;
         b0_q       <= b0_d;
         load0_q    <= load0_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
      end
   end
endmodule

// File: tb/tb_mistral_mac_pipe.sv
// Bench for mistral_mac_pipe: three configurations (signed 18x18, unsigned 27x27,
// mixed 8x8 without product register) checked against an arithmetic model.
module tb_mistral_mac_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        srst_n = 1'b0;
   logic        iv[3], ld[3], ordy[3], irdy[3], ov[3], ovf_o[3];
   logic [26:0] a_s[3], b_s[3];
   logic [63:0] y0;
   logic [53:0] y1;
   logic [31:0] y2;
   logic [63:0] yv[3];

   int     checks = 0, errors = 0, cur = 0;
   longint cyc = 0;
   int     aw[3]   = '{18, 27, 8};
   int     bw[3]   = '{18, 27, 8};
   bit     a_sg[3] = '{1'b1, 1'b0, 1'b1};
   bit     b_sg[3] = '{1'b1, 1'b0, 1'b0};
   int     accw[3] = '{64, 54, 32};
   logic [63:0] macc[3];
   logic        movf[3];
   logic [64:0] exp_q[$], got_q[$];
   longint      got_t[$];
   bit          bp_done, rnd_done;

   mistral_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .A_SIGNED(1), .B_SIGNED(1),
                      .ACC_WIDTH(64), .PRODUCT_REG(1)) u0 (
      .CLK(clk), .SRST_N(srst_n), .IN_VALID(iv[0]), .IN_READY(irdy[0]),
      .A(a_s[0][17:0]), .B(b_s[0][17:0]), .LOAD(ld[0]), .OUT_VALID(ov[0]),
      .OUT_READY(ordy[0]), .Y(y0), .OVF(ovf_o[0]));

   mistral_mac_pipe #(.A_WIDTH(27), .B_WIDTH(27), .A_SIGNED(0), .B_SIGNED(0),
                      .ACC_WIDTH(54), .PRODUCT_REG(1)) u1 (
      .CLK(clk), .SRST_N(srst_n), .IN_VALID(iv[1]), .IN_READY(irdy[1]),
      .A(a_s[1]), .B(b_s[1]), .LOAD(ld[1]), .OUT_VALID(ov[1]),
      .OUT_READY(ordy[1]), .Y(y1), .OVF(ovf_o[1]));

   mistral_mac_pipe #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(1), .B_SIGNED(0),
                      .ACC_WIDTH(32), .PRODUCT_REG(0)) u2 (
      .CLK(clk), .SRST_N(srst_n), .IN_VALID(iv[2]), .IN_READY(irdy[2]),
      .A(a_s[2][7:0]), .B(b_s[2][7:0]), .LOAD(ld[2]), .OUT_VALID(ov[2]),
      .OUT_READY(ordy[2]), .Y(y2), .OVF(ovf_o[2]));

   always_comb begin
      yv[0] = y0;
      yv[1] = {10'b0, y1};
      yv[2] = {32'b0, y2};
   end

   always @(posedge clk) cyc <= cyc + 1;

   // A result is consumed at the edge following a negedge where valid & ready.
   always @(negedge clk) begin
      if (srst_n === 1'b1 && ov[cur] === 1'b1 && ordy[cur] === 1'b1) begin
         got_q.push_back({ovf_o[cur], yv[cur]});
         got_t.push_back(cyc);
      end
   end

   // Reference: exact integer product, true-range overflow test, result mod 2^W.
   function automatic logic [64:0] model(int k, logic [26:0] a, logic [26:0] b, logic load);
      longint av, bv, p;
      logic signed [127:0] accs, sum, lim;
      logic [63:0] mask;
      int  w;
      logic o;
      w  = accw[k];
      av = longint'({37'b0, a}) & ((64'sd1 <<< aw[k]) - 1);
      bv = longint'({37'b0, b}) & ((64'sd1 <<< bw[k]) - 1);
      if (a_sg[k] && av[aw[k]-1]) av = av - (64'sd1 <<< aw[k]);
      if (b_sg[k] && bv[bw[k]-1]) bv = bv - (64'sd1 <<< bw[k]);
      p    = av * bv;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      if (load) return {1'b0, 64'(p) & mask};
      if (a_sg[k] || b_sg[k]) begin
         accs = {64'b0, macc[k]};
         if (macc[k][w-1]) accs = accs - (128'sd1 <<< w);
         sum = accs + 128'(p);
         lim = 128'sd1 <<< (w - 1);
         o   = (sum >= lim) || (sum < -lim);
      end else begin
         sum = {64'b0, macc[k]} + 128'(p);
         o   = (sum >= (128'sd1 <<< w));
      end
      return {movf[k] | o, sum[63:0] & mask};
   endfunction

   task automatic send(input int k, input logic [26:0] a, input logic [26:0] b, input logic load);
      logic [64:0] r;
      int t;
      a_s[k] = a; b_s[k] = b; ld[k] = load; iv[k] = 1'b1;
      t = 0;
      @(negedge clk);
      while (irdy[k] !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (irdy[k] !== 1'b1) begin
         errors++;
         $display("FAIL send_accept dut%0d: IN_READY=%b after %0d cycles, want 1", k, irdy[k], t);
      end else begin
         r = model(k, a, b, load);
         macc[k] = r[63:0];
         movf[k] = r[64];
         exp_q.push_back(r);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int k);
      iv[k] = 1'b0;
   endtask

   task automatic clear_q();
      exp_q.delete(); got_q.delete(); got_t.delete();
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 300; t++) begin
         @(posedge clk); #1;
         if (got_q.size() >= exp_q.size() && ov[cur] !== 1'b1) break;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1; macc[k] = '0; movf[k] = 1'b0;
      end
      srst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      srst_n = 1'b1;
      clear_q();
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         checks += 4;
         if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got %b want 0", k, ov[k]); end
         if (yv[k] !== 64'd0) begin errors++; $display("FAIL reset_y dut%0d got %h want 0", k, yv[k]); end
         if (ovf_o[k] !== 1'b0) begin errors++; $display("FAIL reset_ovf dut%0d got %b want 0", k, ovf_o[k]); end
         if (irdy[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d got %b want 1", k, irdy[k]); end
      end
   endtask

   task automatic test_latency();
      int cnt;
      cur = 0; clear_q();
      send(0, 27'(-3), 27'd7, 1'b1);
      idle(0);
      cnt = 1;
      while (ov[0] !== 1'b1 && cnt < 10) begin @(posedge clk); #1; cnt++; end
      checks += 3;
      if (cnt != 3) begin errors++; $display("FAIL latency_preg got %0d want 3", cnt); end
      if (yv[0] !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL latency_y got %h want ffffffffffffffeb", yv[0]); end
      if (ovf_o[0] !== 1'b0) begin errors++; $display("FAIL latency_ovf got %b want 0", ovf_o[0]); end
      wait_drain();
      checks++;
      if (got_q.size() != 1) begin errors++; $display("FAIL latency_count got %0d want 1", got_q.size()); end
   endtask

   task automatic test_accum();
      logic [63:0] want[3] = '{64'd6, 64'd26, 64'd20};
      cur = 0; clear_q();
      send(0, 27'd2, 27'd3, 1'b1);
      send(0, 27'd4, 27'd5, 1'b0);
      send(0, 27'(-1), 27'd6, 1'b0);
      idle(0);
      wait_drain();
      checks++;
      if (got_q.size() != 3) begin errors++; $display("FAIL accum_count got %0d want 3", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks += 2;
         if (got_q[i] !== {1'b0, want[i]}) begin
            errors++; $display("FAIL accum_beat%0d got y=%0d ovf=%b want y=%0d ovf=0", i, got_q[i][63:0], got_q[i][64], want[i]);
         end
         if (i > 0 && got_t[i] - got_t[i-1] != 1) begin
            errors++; $display("FAIL accum_spacing%0d got %0d cycles want 1", i, got_t[i] - got_t[i-1]);
         end
      end
   endtask

   task automatic test_unsigned_wrap();
      logic [64:0] want[3];
      want[0] = {1'b0, 64'h003F_FFFF_F000_0001};
      want[1] = {1'b1, 64'h003F_FFFF_E000_0002};
      want[2] = {1'b0, 64'd1};
      cur = 1; clear_q();
      send(1, 27'h7FF_FFFF, 27'h7FF_FFFF, 1'b1);
      send(1, 27'h7FF_FFFF, 27'h7FF_FFFF, 1'b0);
      send(1, 27'd1, 27'd1, 1'b1);
      idle(1);
      wait_drain();
      checks++;
      if (got_q.size() != 3) begin errors++; $display("FAIL uwrap_count got %0d want 3", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks++;
         if (got_q[i] !== want[i]) begin
            errors++; $display("FAIL uwrap_beat%0d got y=%h ovf=%b want y=%h ovf=%b", i, got_q[i][63:0], got_q[i][64], want[i][63:0], want[i][64]);
         end
      end
   endtask

   task automatic test_backpressure();
      cur = 0; clear_q();
      ordy[0] = 1'b0;
      bp_done = 1'b0;
      fork
         begin
            send(0, 27'($urandom()), 27'($urandom()), 1'b1);
            for (int i = 0; i < 3; i++) send(0, 27'($urandom()), 27'($urandom()), 1'b0);
            idle(0);
            bp_done = 1'b1;
         end
      join_none
      repeat (10) @(posedge clk);
      #1;
      checks += 4;
      if (irdy[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", irdy[0]); end
      if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", ov[0]); end
      if (exp_q.size() != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", exp_q.size()); end
      if (got_q.size() != 0) begin errors++; $display("FAIL bp_consumed got %0d want 0", got_q.size()); end
      ordy[0] = 1'b1;
      for (int t = 0; t < 100 && !bp_done; t++) @(posedge clk);
      wait_drain();
      checks++;
      if (got_q.size() != 4 || exp_q.size() != 4) begin
         errors++; $display("FAIL bp_count got %0d want 4 (sent %0d)", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_beat%0d got y=%h ovf=%b want y=%h ovf=%b", i, got_q[i][63:0], got_q[i][64], exp_q[i][63:0], exp_q[i][64]);
         end
      end
   endtask

   task automatic test_mixed();
      int cnt;
      cur = 2; clear_q();
      send(2, 27'h0FF, 27'h0FF, 1'b1);
      idle(2);
      cnt = 1;
      while (ov[2] !== 1'b1 && cnt < 10) begin @(posedge clk); #1; cnt++; end
      checks += 3;
      if (cnt != 2) begin errors++; $display("FAIL mixed_latency got %0d want 2", cnt); end
      if (yv[2] !== 64'h0000_0000_FFFF_FF01) begin errors++; $display("FAIL mixed_y got %h want ffffff01", yv[2]); end
      if (ovf_o[2] !== 1'b0) begin errors++; $display("FAIL mixed_ovf got %b want 0", ovf_o[2]); end
      wait_drain();
   endtask

   task automatic test_random(input int k);
      cur = k; clear_q();
      rnd_done = 1'b0;
      fork
         while (!rnd_done) begin
            @(posedge clk); #1;
            if (!rnd_done) ordy[k] = ($urandom_range(0, 3) != 0);
         end
      join_none
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin idle(k); @(posedge clk); #1; end
         send(k, 27'($urandom()), 27'($urandom()), ($urandom_range(0, 3) == 0));
      end
      idle(k);
      rnd_done = 1'b1;
      @(posedge clk); #2;
      ordy[k] = 1'b1;
      wait_drain();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand%0d_count got %0d want %0d", k, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand%0d_beat%0d got y=%h ovf=%b want y=%h ovf=%b", k, i, got_q[i][63:0], got_q[i][64], exp_q[i][63:0], exp_q[i][64]);
         end
      end
   endtask

   task automatic test_reset_inflight();
      cur = 0; clear_q();
      send(0, 27'd5, 27'd5, 1'b1);
      send(0, 27'd7, 27'd7, 1'b0);
      idle(0);
      srst_n = 1'b0;
      @(posedge clk); #1;
      srst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin macc[k] = '0; movf[k] = 1'b0; end
      clear_q();
      checks += 3;
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL rst_fly_out_valid got %b want 0", ov[0]); end
      if (yv[0] !== 64'd0) begin errors++; $display("FAIL rst_fly_y got %h want 0", yv[0]); end
      if (ovf_o[0] !== 1'b0) begin errors++; $display("FAIL rst_fly_ovf got %b want 0", ovf_o[0]); end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (got_q.size() != 0) begin errors++; $display("FAIL rst_fly_ghost got %0d results want 0", got_q.size()); end
      send(0, 27'd1, 27'd1, 1'b0);
      idle(0);
      wait_drain();
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {1'b0, 64'd1}) begin
         errors++; $display("FAIL rst_fly_post got %0d results, first y=%h want 1 result y=1", got_q.size(), (got_q.size() > 0) ? got_q[0][63:0] : 64'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; ld[k] = 1'b0; ordy[k] = 1'b1; a_s[k] = '0; b_s[k] = '0;
      end
      apply_reset();
      test_reset();
      test_latency();
      test_accum();
      test_unsigned_wrap();
      test_backpressure();
      test_mixed();
      for (int k = 0; k < 3; k++) test_random(k);
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mistral_mac_pipe.md
Name: mistral_mac_pipe

Overview:
Pipelined, parametrised multiply-accumulate block for the Mistral (Cyclone V) DSP flow. It generalises the fixed 9x9, 18x18 and 27x27 multiplier mappings in three ways: operand widths up to 27x27 with selectable signedness, optional product register, and a wide accumulator with per-beat load/accumulate control. It has valid/ready flow control and a sticky overflow flag, and it sits between datapath logic and the DSP column.

Parameters:
A_WIDTH, 18, width of operand A; legal range 1..27.
B_WIDTH, 18, width of operand B; legal range 1..27.
A_SIGNED, 1, 1 = A is two's complement; 0 = unsigned.
B_SIGNED, 1, 1 = B is two's complement; 0 = unsigned.
ACC_WIDTH, 64, accumulator and Y width; legal range A_WIDTH+B_WIDTH..64.
PRODUCT_REG, 1, 1 = register the product stage (latency 3); 0 = no product register (latency 2).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
SRST_N  input  1  synchronous active-low reset.
IN_VALID  input  1  input beat present.
IN_READY  output  1  block can accept a beat this cycle.
A  input  A_WIDTH  multiplicand.
B  input  B_WIDTH  multiplier.
LOAD  input  1  1 = start a new accumulation (acc = product); 0 = acc = acc + product.
OUT_VALID  output  1  Y/OVF hold a result.
OUT_READY  input  1  downstream accepts the result.
Y  output  ACC_WIDTH  accumulator value after this beat.
OVF  output  1  sticky overflow for the current accumulation.

Behaviour:
- Reset: when SRST_N=0 at a clock edge, all stage valids, the accumulator, Y and OVF are cleared to 0. Beats in flight are discarded. IN_READY is 1 in the cycle after reset.
- Elaboration: out-of-range parameters must cause an $error at elaboration.
- Stall: stall = OUT_VALID & ~OUT_READY; IN_READY = ~stall.
  - During a stall every stage register, the accumulator and OVF hold their values.
  - An input beat is accepted on a cycle with IN_VALID & IN_READY.
- Stage 0 (input register): captures A, B and LOAD from the accepted beat.
- Stage 1 (product register, present only if PRODUCT_REG=1): P = A*B.
  - P is A_WIDTH+B_WIDTH bits wide.
  - The product is signed if either operand is signed; an unsigned operand is zero-extended by one bit first.
- Stage 2 (accumulate/output stage):
  - P is sign- or zero-extended to ACC_WIDTH.
  - If LOAD=1: acc = P_ext.
  - If LOAD=0: acc = acc + P_ext, modulo 2^ACC_WIDTH (wraps).
  - Y = acc. OUT_VALID is set for that beat.
- Latency: from acceptance to OUT_VALID is 3 cycles with PRODUCT_REG=1 and 2 cycles with PRODUCT_REG=0. Throughput is 1 beat per cycle when there is no stall.
- OUT_VALID drops when a result is consumed (OUT_READY=1) and no new beat reaches stage 2 in that cycle.
- OVF:
  - On a LOAD beat, OVF is cleared to 0; a single product cannot overflow because ACC_WIDTH >= A_WIDTH+B_WIDTH.
  - On an accumulate beat, OVF is set on overflow. In signed mode (either operand signed), overflow means the operands have the same sign and the result sign differs. In unsigned mode, overflow means a carry out of bit ACC_WIDTH-1.
  - Once set, OVF stays 1 until the next LOAD beat or reset.
- First beat after reset with LOAD=0: it accumulates onto 0, which is legal.
- Bubbles (cycles with no valid beat) do not modify acc or OVF.
- Simultaneous consume and new result: when OUT_READY=1 and a new beat reaches stage 2 in the same cycle, Y updates and OUT_VALID stays 1.
- Reset during a stall: reset wins; all outputs are 0 next cycle.

Test Plan:
1. Signed 18x18, PRODUCT_REG=1: beat A=-3, B=7, LOAD=1 -> 3 cycles later OUT_VALID=1, Y=-21 sign-extended to 64 bits, OVF=0.
2. Accumulate run: LOAD=1 A=2 B=3, then LOAD=0 A=4 B=5, then LOAD=0 A=-1 B=6, back-to-back -> Y sequence 6, 26, 20 on consecutive cycles.
3. Unsigned 27x27, ACC_WIDTH=54: LOAD=1 with A=B=2^27-1, then LOAD=0 with the same operands -> second Y wraps mod 2^54 with OVF=1. A following LOAD=1 beat with A=1, B=1 -> Y=1, OVF=0.
4. Backpressure: hold OUT_READY=0 over 4 beats -> IN_READY=0 while OUT_VALID=1, no beat lost or duplicated. Release OUT_READY -> results appear in order with correct sums.
5. PRODUCT_REG=0 with a mixed-sign case (A signed = -1, B unsigned = 255) -> latency 2, Y=-255.
6. Assert SRST_N=0 with two beats in flight -> next cycle OUT_VALID=0, Y=0, OVF=0. A post-reset LOAD=0 beat with A=1, B=1 -> Y=1.
